// File: rtl/fc8_vga_capture.sv
// rtl/fc8_vga_capture.sv - passive VGA sink: sync tracking, active-pixel stream, frame statistics
// Define FC8_VGA_CAP_CRC_EN to build the CRC-16-CCITT frame checksum; otherwise frame_crc is 0.
module fc8_vga_capture #(
    parameter int COLOR_W  = 3,
    parameter int H_START  = 48,
    parameter int H_ACTIVE = 256,
    parameter int V_START  = 3,
    parameter int V_ACTIVE = 240
) (
    input  logic                   master_clk,
    input  logic                   master_rst_n,
    input  logic                   pix_ce,
    input  logic                   vga_hsync,
    input  logic                   vga_vsync,
    input  logic [COLOR_W-1:0]     vga_r,
    input  logic [COLOR_W-1:0]     vga_g,
    input  logic [COLOR_W-1:0]     vga_b,
    input  logic                   clr_err,
    output logic                   pix_valid,
    output logic [8:0]             pix_x,
    output logic [7:0]             pix_y,
    output logic [3*COLOR_W-1:0]   pix_rgb,
    output logic                   frame_done,
    output logic [15:0]            frame_count,
    output logic [9:0]             frame_lines,
    output logic [11:0]            line_period,
    output logic [16:0]            active_pix,
    output logic [15:0]            frame_crc,
    output logic                   err_line_len,
    output logic                   err_frame_short
);
    localparam int RGB_W = 3 * COLOR_W;

    localparam logic [0:0] ST_SEEK  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    localparam logic [11:0] H_LO      = 12'(H_START);
    localparam logic [11:0] H_HI      = 12'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO      = 10'(V_START);
    localparam logic [9:0]  V_HI      = 10'(V_START + V_ACTIVE);
    localparam logic [16:0] FRAME_PIX = 17'(H_ACTIVE * V_ACTIVE);

    logic [0:0]       state;
    logic             hs_q;
    logic             vs_q;
    logic             have_period;
    logic [11:0]      h_cnt;
    logic [9:0]       v_cnt;
    logic [16:0]      acc_pix;

    logic             hs_edge;
    logic             vs_edge;
    logic             frame_close;
    logic             active;
    logic             period_bad;
    logic [11:0]      h_period;
    logic [16:0]      acc_pix_nxt;
    logic [RGB_W-1:0] rgb;

    assign rgb         = {vga_r, vga_g, vga_b};
    assign hs_edge     = pix_ce && hs_q && !vga_hsync;
    assign vs_edge     = pix_ce && vs_q && !vga_vsync;
    assign frame_close = vs_edge && (state == ST_FRAME);
    assign active      = pix_ce && (state == ST_FRAME) && vga_hsync && vga_vsync &&
                         (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                         (v_cnt >= V_LO) && (v_cnt < V_HI);
    assign h_period    = (h_cnt == 12'hFFF) ? 12'hFFF : h_cnt + 12'd1;
    // A coincident vsync opens a new frame first, so that hsync edge has no predecessor to compare.
    assign period_bad  = hs_edge && !vs_edge && (state == ST_FRAME) && have_period &&
                         (h_period != line_period);
    assign acc_pix_nxt = acc_pix + {16'd0, active};

    always_ff @(posedge master_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state       <= ST_SEEK;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            have_period <= 1'b0;
            h_cnt       <= 12'd0;
            v_cnt       <= 10'd0;
            acc_pix     <= 17'd0;
            pix_valid   <= 1'b0;
            pix_x       <= 9'd0;
            pix_y       <= 8'd0;
            pix_rgb     <= '0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
            frame_lines <= 10'd0;
            line_period <= 12'd0;
            active_pix  <= 17'd0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_ce) begin
                hs_q <= vga_hsync;
                vs_q <= vga_vsync;

                if (hs_edge)
                    h_cnt <= 12'd0;
                else if (h_cnt != 12'hFFF)
                    h_cnt <= h_cnt + 12'd1;

                if (vs_edge)
                    v_cnt <= 10'd0;
                else if (hs_edge && v_cnt != 10'h3FF)
                    v_cnt <= v_cnt + 10'd1;

                if (hs_edge)
                    line_period <= h_period;

                if (vs_edge) begin
                    state       <= ST_FRAME;
                    have_period <= hs_edge;
                    acc_pix     <= 17'd0;
                end else begin
                    if (hs_edge)
                        have_period <= 1'b1;
                    acc_pix <= acc_pix_nxt;
                end

                if (active) begin
                    pix_valid <= 1'b1;
                    pix_x     <= 9'(h_cnt - H_LO);
                    pix_y     <= 8'(v_cnt - V_LO);
                    pix_rgb   <= rgb;
                end

                if (frame_close) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                    frame_lines <= v_cnt;
                    active_pix  <= acc_pix_nxt;
                end
            end
        end
    end

    always_ff @(posedge master_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            err_line_len    <= 1'b0;
            err_frame_short <= 1'b0;
        end else begin
            if (period_bad)
                err_line_len <= 1'b1;
            else if (clr_err)
                err_line_len <= 1'b0;

            if (frame_close && acc_pix_nxt != FRAME_PIX)
                err_frame_short <= 1'b1;
            else if (clr_err)
                err_frame_short <= 1'b0;
        end
    end

`ifdef FC8_VGA_CAP_CRC_EN
    // One pixel per strobe: all RGB bits are folded in a single cycle, MSB of r first.
    function automatic logic [15:0] crc_update(input logic [15:0] crc_in,
                                               input logic [RGB_W-1:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = RGB_W - 1; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    logic [15:0] acc_crc;
    logic [15:0] acc_crc_nxt;

    assign acc_crc_nxt = active ? crc_update(acc_crc, rgb) : acc_crc;

    always_ff @(posedge master_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            acc_crc   <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else if (pix_ce) begin
            if (frame_close)
                frame_crc <= acc_crc_nxt;
            acc_crc <= vs_edge ? 16'hFFFF : acc_crc_nxt;
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_fc8_vga_capture.sv
// tb/tb_fc8_vga_capture.sv - directed bench for fc8_vga_capture on a 4x2 active, 10x5 total raster
module tb_fc8_vga_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        clr = 1'b0;
    logic [2:0]  r = 3'd0;
    logic [2:0]  g = 3'd0;
    logic [2:0]  b = 3'd0;

    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [8:0]  pix_rgb;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [9:0]  frame_lines;
    logic [11:0] line_period;
    logic [16:0] active_pix;
    logic [15:0] frame_crc;
    logic        err_line_len;
    logic        err_frame_short;

    fc8_vga_capture #(
        .COLOR_W (3),
        .H_START (2),
        .H_ACTIVE(4),
        .V_START (1),
        .V_ACTIVE(2)
    ) dut (
        .master_clk     (clk),
        .master_rst_n   (rst_n),
        .pix_ce         (pix_ce),
        .vga_hsync      (hs),
        .vga_vsync      (vs),
        .vga_r          (r),
        .vga_g          (g),
        .vga_b          (b),
        .clr_err        (clr),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_rgb        (pix_rgb),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .frame_lines    (frame_lines),
        .line_period    (line_period),
        .active_pix     (active_pix),
        .frame_crc      (frame_crc),
        .err_line_len   (err_line_len),
        .err_frame_short(err_frame_short)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [25:0] pix_q[$];
    logic        flip = 1'b0;

    always @(negedge clk) begin
        if (pix_valid)
            pix_q.push_back({pix_y, pix_x, pix_rgb});
        if (frame_done)
            done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_xy"}, 32'({pix_x, pix_y}), 32'd0);
        check({tag, "_rgb"}, 32'(pix_rgb), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_count"}, 32'(frame_count), 32'd0);
        check({tag, "_lines"}, 32'(frame_lines), 32'd0);
        check({tag, "_period"}, 32'(line_period), 32'd0);
        check({tag, "_apix"}, 32'(active_pix), 32'd0);
        check({tag, "_crc"}, 32'(frame_crc), 32'd0);
        check({tag, "_errs"}, 32'({err_line_len, err_frame_short}), 32'd0);
    endtask

    task automatic strobe(input logic h, input logic v, input logic [8:0] rgb, input logic c);
        pix_ce = 1'b1;
        hs = h;
        vs = v;
        {r, g, b} = rgb;
        clr = c;
        @(negedge clk);
        pix_ce = 1'b0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // hsync low on strobe 0; active pixels land on strobes 3..6 carrying value x+4*row.
    task automatic run_line(input int len, input int vs_at, input int row, input int clr_at);
        logic [8:0] v;
        for (int s = 0; s < len; s++) begin
            v = 9'd0;
            if (row >= 0 && s >= 3 && s <= 6)
                v = 9'(s - 3 + 4 * row);
            if (flip && row == 0 && s == 3)
                v = v ^ 9'h100;
            strobe(s != 0, s != vs_at, v, s == clr_at);
        end
    endtask

    task automatic frame_std();
        run_line(10, 8, -1, -1);
        run_line(10, -1, 0, -1);
        run_line(10, -1, 1, -1);
        run_line(10, -1, -1, -1);
        run_line(10, -1, -1, -1);
    endtask

`ifdef FC8_VGA_CAP_CRC_EN
    function automatic logic [15:0] crc_frame(input logic flip0);
        logic [15:0] c;
        logic [8:0]  d;
        c = 16'hFFFF;
        for (int p = 0; p < 8; p++) begin
            d = 9'(p);
            if (flip0 && p == 0)
                d = d ^ 9'h100;
            for (int i = 8; i >= 0; i--)
                c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    initial begin
        logic [15:0] crc1;
        logic [25:0] e;
        int          qs;
        int          done0;

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frames: the first vsync only synchronises, the second closes frame 1.
        frame_std();
        frame_std();
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("count1", 32'(frame_count), 32'd1);
        check("lines1", 32'(frame_lines), 32'd5);
        check("period1", 32'(line_period), 32'd10);
        check("apix1", 32'(active_pix), 32'd8);
        check("errs1", 32'({err_line_len, err_frame_short}), 32'd0);
        check("pix_n", 32'(pix_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < pix_q.size(); i++) begin
            e = {8'((i % 8) / 4), 9'(i % 4), 9'(i % 8)};
            check($sformatf("pix%0d", i), 32'(pix_q[i]), 32'(e));
        end
        crc1 = frame_crc;
`ifdef FC8_VGA_CAP_CRC_EN
        check("crc1", 32'(crc1), 32'(crc_frame(1'b0)));
        check("crc1_nz", 32'(crc1 != 16'd0), 32'd1);
`else
        check("crc1_off", 32'(crc1), 32'd0);
`endif

        frame_std();
        check("count2", 32'(frame_count), 32'd2);
        check("crc_repeat", 32'(frame_crc), 32'(crc1));

        flip = 1'b1;
        frame_std();
        flip = 1'b0;
        frame_std();
        check("count4", 32'(frame_count), 32'd4);
        check("apix_flip", 32'(active_pix), 32'd8);
`ifdef FC8_VGA_CAP_CRC_EN
        check("crc_flip", 32'(frame_crc), 32'(crc_frame(1'b1)));
        check("crc_flip_diff", 32'(frame_crc != crc1), 32'd1);
`else
        check("crc_flip_off", 32'(frame_crc), 32'd0);
`endif

        // One 9-strobe line mid-frame.
        run_line(10, 8, -1, -1);
        run_line(10, -1, 0, -1);
        run_line(10, -1, 1, -1);
        run_line(9, -1, -1, -1);
        run_line(10, -1, -1, -1);
        check("len_err_set", 32'(err_line_len), 32'd1);
        check("period9", 32'(line_period), 32'd9);
        check("short_clean", 32'(err_frame_short), 32'd0);
        frame_std();
        check("len_err_sticky", 32'(err_line_len), 32'd1);
        check("count6", 32'(frame_count), 32'd6);
        run_line(10, 8, -1, 5);
        check("len_err_clr", 32'(err_line_len), 32'd0);
        run_line(10, -1, 0, -1);
        run_line(10, -1, 1, -1);
        run_line(9, -1, -1, -1);
        run_line(10, -1, -1, 0);
        check("len_err_set_wins", 32'(err_line_len), 32'd1);

        // Three-line frame, then a frame cut before its second active row.
        run_line(10, 8, -1, -1);
        run_line(10, -1, 0, 5);
        run_line(10, -1, 1, -1);
        run_line(10, 8, -1, -1);
        check("lines3", 32'(frame_lines), 32'd3);
        check("apix3", 32'(active_pix), 32'd8);
        check("errs3", 32'({err_line_len, err_frame_short}), 32'd0);
        check("count9", 32'(frame_count), 32'd9);
        run_line(10, -1, 0, -1);
        run_line(10, 1, -1, -1);
        check("lines_short", 32'(frame_lines), 32'd2);
        check("apix_short", 32'(active_pix), 32'd4);
        check("short_set", 32'(err_frame_short), 32'd1);
        check("done10", 32'(done_cnt), 32'd10);

        // Reset while a pixel is being presented.
        strobe(1'b0, 1'b1, 9'd0, 1'b0);
        strobe(1'b1, 1'b1, 9'd0, 1'b0);
        strobe(1'b1, 1'b1, 9'd0, 1'b0);
        pix_ce = 1'b1;
        {r, g, b} = 9'd5;
        @(negedge clk);
        pix_ce = 1'b0;
        check("pre_rst_valid", 32'(pix_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qs = pix_q.size();
        done0 = done_cnt;
        run_line(10, -1, 0, -1);
        run_line(10, -1, 1, -1);
        check("seek_no_pix", 32'(pix_q.size()), 32'(qs));
        run_line(10, 8, -1, -1);
        check("seek_count", 32'(frame_count), 32'd0);
        check("seek_no_done", 32'(done_cnt), 32'(done0));

        // Coincident hsync/vsync close.
        run_line(10, -1, 0, -1);
        run_line(10, -1, 1, -1);
        run_line(10, -1, -1, -1);
        run_line(10, -1, -1, -1);
        run_line(10, 0, -1, -1);
        check("sim_lines", 32'(frame_lines), 32'd4);
        check("sim_apix", 32'(active_pix), 32'd8);
        check("sim_count", 32'(frame_count), 32'd1);
        check("sim_done_once", 32'(done_cnt), 32'(done0 + 1));
        qs = pix_q.size();
        run_line(10, -1, 0, -1);
        check("sim_row_n", 32'(pix_q.size()), 32'(qs + 4));
        for (int i = 0; i < 4 && qs + i < pix_q.size(); i++) begin
            e = {8'd0, 9'(i), 9'(i)};
            check($sformatf("sim_pix%0d", i), 32'(pix_q[qs + i]), 32'(e));
        end
        run_line(10, -1, 1, -1);
        run_line(10, -1, -1, -1);
        run_line(10, -1, -1, -1);
        run_line(10, 8, -1, -1);
        check("sim_next_lines", 32'(frame_lines), 32'd5);
        check("sim_next_count", 32'(frame_count), 32'd2);
        check("sim_next_errs", 32'({err_line_len, err_frame_short}), 32'd0);
        check("sim_next_done", 32'(done_cnt), 32'(done0 + 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc8_vga_capture.md
# fc8_vga_capture

Passive VGA sink for the FC8 system: samples the graphics unit's `vga_hsync`/`vga_vsync`/`vga_r`/`vga_g`/`vga_b` on each pixel-clock enable and reconstructs frame/line/pixel coordinates. Emits an active-pixel stream for frame dumping, per-frame statistics and a frame checksum, and flags sync-timing errors. Instantiated beside `fc8_graphics` inside `fc8_system` (or in benches) so scrolling, flipping and SBO effects are checked by value instead of waveform inspection.

## Interface
- `COLOR_W`, 3: bits per colour channel.
- `H_START`, 48: pixel strobes from hsync falling edge to first active pixel.
- `H_ACTIVE`, 256: active pixels per line.
- `V_START`, 3: hsync falling edges from vsync falling edge to first active line.
- `V_ACTIVE`, 240: active lines per frame.

- `master_clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `master_rst_n`  in  1  asynchronous active-low reset.
- `pix_ce`  in  1  pixel-clock enable (master_clk/4). All sampling happens only when high.
- `vga_hsync`, `vga_vsync`  in  1  active-low syncs.
- `vga_r`, `vga_g`, `vga_b`  in  COLOR_W  pixel colour.
- `clr_err`  in  1  clears sticky error flags.
- `pix_valid`  out  1  one-cycle pulse per captured active pixel.
- `pix_x`  out  9  active-relative column.
- `pix_y`  out  8  active-relative row.
- `pix_rgb`  out  3*COLOR_W  {r,g,b}.
- `frame_done`  out  1  one-cycle pulse at end of each complete frame.
- `frame_count`  out  16  completed frames, wraps 0xFFFF->0.
- `frame_lines`  out  10  hsync edges counted in last frame.
- `line_period`  out  12  pix_ce strobes between last two hsync falling edges.
- `active_pix`  out  17  active pixels captured in last frame.
- `frame_crc`  out  16  checksum of last frame's active pixels.
- `err_line_len`, `err_frame_short`  out  1  sticky errors.

## Operation
- On pix_ce: edge = current sync sample 0 while previous sample (`hs_q`/`vs_q`, updated only on pix_ce) is 1. Reset value of both `hs_q` and `vs_q`: 1.
- `h_cnt` (12 b): 0 on hsync edge, else +1, saturating at 0xFFF. `v_cnt` (10 b): 0 on vsync edge, +1 on each hsync edge, saturating.
- FSM states: SEEK (after reset; ignore everything until a vsync edge), FRAME (capturing). SEEK->FRAME on vsync edge. FRAME->FRAME on vsync edge, with frame close.
- Active pixel: state FRAME, both syncs high, H_START<=h_cnt<H_START+H_ACTIVE, V_START<=v_cnt<V_START+V_ACTIVE. Produces pix_valid with pix_x=h_cnt-H_START, pix_y=v_cnt-V_START.
- Frame close (vsync edge in FRAME): latch frame_lines=v_cnt, active_pix, frame_crc. Pulse frame_done. frame_count+1. Set err_frame_short if active_pix != H_ACTIVE*V_ACTIVE. Reset the running accumulators for the next frame. The first vsync edge out of SEEK closes no frame.
- Line length: on each hsync edge, line_period<=h_cnt+1. Within a frame, from the second edge onward, set err_line_len if the new period differs from the previous one.
- Simultaneous hsync and vsync edges: process the vsync first (v_cnt=0, frame close). The hsync edge then clears h_cnt but does not increment v_cnt.
- clr_err clears both errors. A same-cycle set wins over clear.
- Reset mid-frame: all outputs reset and the FSM returns to SEEK. The partial frame is discarded.
- Reset values: every output 0, FSM=SEEK.

## Timing
- pix_valid, pix_x/y/rgb are registered: valid the master_clk cycle after the sampling pix_ce cycle, held for one cycle.
- frame_done and the latched statistics update in the same registered cycle, one cycle after the closing vsync pix_ce.
- The frame statistics include the last active pixel even when it coincides with the frame close.
- No back-pressure; pix_valid pulses are at most one per pix_ce.

## Configuration
- `FC8_VGA_CAP_CRC_EN` defined:
  - frame_crc is CRC-16-CCITT: polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Computed over each active pixel's {r,g,b} bits, MSB of r first, 3*COLOR_W bits per pixel in one cycle.
- Undefined: no CRC logic is built and frame_crc is constant 0x0000. All other behaviour is identical.

## Test plan
- Small-config bench (H_START=2, H_ACTIVE=4, V_START=1, V_ACTIVE=2, line period 10, 5 lines/frame, constant rgb): second frame -> frame_done pulse, frame_lines=5, line_period=10, active_pix=8, frame_count=1, no errors; 8 pix_valid pulses, x 0..3, y 0..1.
- Pixel value = x+4y -> pix_rgb sequence 0..7 in order. With CRC_EN, two identical frames give equal nonzero frame_crc, and flipping one pixel changes it. Without CRC_EN, frame_crc=0.
- One line shortened to 9 strobes -> err_line_len=1 and stays set across frames until clr_err. clr_err coincident with a new mismatch -> remains 1.
- Vsync after 3 lines -> frame_lines=3, active_pix=8 (if V_ACTIVE fits) or less with err_frame_short=1.
- Reset asserted mid-line during active output -> all outputs 0 immediately. After release, pix_valid stays low until the first vsync edge, and frame_count is still 0 after that edge.
- Hsync and vsync falling on the same pix_ce -> v_cnt=0, the next line counts as 1, frame_done fires once.
